// File: rtl/rule_scheduler_if.sv
// rule_scheduler_if
//   Bundles the scheduler's guard/run inputs and its rule-select, fire,
//   deadlock and fire-count outputs.
//   master : the downstream system / environment (drives guards and run)
//   slave  : the rule scheduler (drives the rule select and status)
//   io_guard      - bit i high = rule i currently enabled
//   io_run        - high = scheduling permitted, low = pause
//   io_en_a       - encoded rule select, 0 = none, k = rule k-1 fires
//   io_fire       - high exactly when io_en_a is nonzero
//   io_deadlock   - sticky deadlock flag
//   io_fire_count - number of rules issued since reset (wraps)
interface rule_scheduler_if #(
    parameter int NUM_RULES = 7,
    parameter int EN_W      = 3
);
    logic [NUM_RULES-1:0] io_guard;
    logic                 io_run;
    logic [EN_W-1:0]      io_en_a;
    logic                 io_fire;
    logic                 io_deadlock;
    logic [15:0]          io_fire_count;

    modport master (
        output io_guard, io_run,
        input  io_en_a, io_fire, io_deadlock, io_fire_count
    );

    modport slave (
        input  io_guard, io_run,
        output io_en_a, io_fire, io_deadlock, io_fire_count
    );
endinterface

// File: rtl/rule_scheduler.sv
// rule_scheduler
//   Round-robin scheduler for a set of guarded rules. While running it
//   picks, each cycle, the next enabled rule after the last one granted
//   and presents it (registered, one cycle later) as an encoded select.
//   A run of STALL_LIMIT consecutive cycles with no enabled rule is
//   treated as deadlock, which only reset clears.
//   clock - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - rule_scheduler_if slave port (guards/run in, select/status out)
module rule_scheduler #(
    parameter int NUM_RULES   = 7,
    parameter int EN_W        = 3,
    parameter int STALL_LIMIT = 15
) (
    input  logic            clock,
    input  logic            reset,
    rule_scheduler_if.slave bus
);
    localparam int                 STALL_W     = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [EN_W-1:0]    LAST_RULE   = EN_W'(NUM_RULES - 1);
    localparam logic [EN_W:0]      NUM_RULES_W = (EN_W + 1)'(NUM_RULES);
    localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(STALL_LIMIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        DEADLOCK = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [EN_W-1:0]      en_a_q, en_a_d;
    logic [EN_W-1:0]      last_q, last_d;
    logic [15:0]          count_q, count_d;
    logic [STALL_W-1:0]   stall_q, stall_d;

    // Round-robin search signals
    logic [EN_W-1:0]        start_idx;
    logic [EN_W-1:0]        offset;
    logic [EN_W-1:0]        sel_idx;
    logic [EN_W:0]          sel_sum;
    logic [2*NUM_RULES-1:0] guard_x2;
    logic [2*NUM_RULES-1:0] guard_shift;
    logic [NUM_RULES-1:0]   guard_rot;
    logic                   any_guard;

    // Rotate the guards so the search start sits at bit 0, take the lowest
    // set bit, then map the offset back to an absolute rule index.
    always_comb begin
        start_idx   = (last_q == LAST_RULE) ? '0 : last_q + EN_W'(1);
        guard_x2    = {bus.io_guard, bus.io_guard};
        guard_shift = guard_x2 >> start_idx;
        guard_rot   = guard_shift[NUM_RULES-1:0];
        any_guard   = |bus.io_guard;
        offset      = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (guard_rot[i]) offset = EN_W'(i);
        end
        sel_sum = {1'b0, start_idx} + {1'b0, offset};
        if (sel_sum >= NUM_RULES_W) sel_sum = sel_sum - NUM_RULES_W;
        sel_idx = sel_sum[EN_W-1:0];
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        en_a_d  = '0;
        last_d  = last_q;
        count_d = count_q;
        stall_d = stall_q;
        unique case (state_q)
            IDLE: begin
                if (bus.io_run) state_d = RUN;
            end
            RUN: begin
                if (!bus.io_run) begin
                    // Pause wins over any enabled guard this cycle.
                    state_d = IDLE;
                end else if (any_guard) begin
                    en_a_d  = sel_idx + EN_W'(1);
                    last_d  = sel_idx;
                    count_d = count_q + 16'd1;
                    stall_d = '0;
                end else begin
                    if (stall_q != STALL_MAX) stall_d = stall_q + STALL_W'(1);
                    if (stall_d == STALL_MAX) state_d = DEADLOCK;
                end
            end
            DEADLOCK: begin
                state_d = DEADLOCK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            en_a_q  <= '0;
            last_q  <= LAST_RULE;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            en_a_q  <= en_a_d;
            last_q  <= last_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    assign bus.io_en_a       = en_a_q;
    assign bus.io_fire       = |en_a_q;
    assign bus.io_deadlock   = (state_q == DEADLOCK);
    assign bus.io_fire_count = count_q;
endmodule

// File: tb/tb_rule_scheduler.sv
module tb_rule_scheduler;
    localparam int NR    = 7;
    localparam int EW    = 3;
    localparam int LIMIT = 15;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    rule_scheduler_if #(.NUM_RULES(NR), .EN_W(EW)) bus ();

    rule_scheduler #(
        .NUM_RULES  (NR),
        .EN_W       (EW),
        .STALL_LIMIT(LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Behavioural model: scheduling is allowed only while active and not
    // dead; a grant goes to the first enabled rule scanning forward from
    // the rule after the last grant, shown one cycle later.
    // ------------------------------------------------------------------
    bit          m_active;
    bit          m_dead;
    int          m_last;
    int          m_stall;
    int          m_en;
    logic [15:0] m_count;

    always @(posedge clock or posedge reset) begin
        int pick;
        int cand;
        if (reset) begin
            m_active <= 1'b0;
            m_dead   <= 1'b0;
            m_last   <= NR - 1;
            m_stall  <= 0;
            m_en     <= 0;
            m_count  <= 16'd0;
        end else begin
            m_en <= 0;
            if (m_dead) begin
                m_dead <= 1'b1;
            end else if (!m_active) begin
                if (bus.io_run) m_active <= 1'b1;
            end else if (!bus.io_run) begin
                m_active <= 1'b0;
            end else if (bus.io_guard != '0) begin
                pick = -1;
                for (int k = 1; k <= NR; k++) begin
                    cand = (m_last + k) % NR;
                    if (pick < 0 && bus.io_guard[cand]) pick = cand;
                end
                m_en    <= pick + 1;
                m_last  <= pick;
                m_count <= m_count + 16'd1;
                m_stall <= 0;
            end else begin
                m_stall <= (m_stall + 1 > LIMIT) ? LIMIT : m_stall + 1;
                if (m_stall + 1 >= LIMIT) begin
                    m_dead   <= 1'b1;
                    m_active <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every cycle: DUT outputs must match the model.
    always @(negedge clock) begin
        check("model en_a", 32'(bus.io_en_a), 32'(m_en));
        check("model fire", 32'(bus.io_fire), 32'(m_en != 0));
        check("model deadlock", 32'(bus.io_deadlock), 32'(m_dead));
        check("model fire_count", 32'(bus.io_fire_count), 32'(m_count));
    end

    // Drive inputs away from the edge, let one rising edge pass, return
    // at the following falling edge with outputs settled.
    task automatic tick(input logic r, input logic [NR-1:0] g);
        bus.io_run   = r;
        bus.io_guard = g;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        bus.io_run   = 1'b0;
        bus.io_guard = '0;
        reset        = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("reset en_a", 32'(bus.io_en_a), 32'd0);
        check("reset fire", 32'(bus.io_fire), 32'd0);
        check("reset deadlock", 32'(bus.io_deadlock), 32'd0);
        check("reset fire_count", 32'(bus.io_fire_count), 32'd0);
        reset = 1'b0;
    endtask

    task automatic tick_en(input string name, input logic r, input logic [NR-1:0] g,
                           input int exp_en);
        tick(r, g);
        check(name, 32'(bus.io_en_a), 32'(exp_en));
    endtask

    initial begin
        int seq25[5];
        int seq28_en[5];
        bit seq28_run[5];
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.io_run   = 1'b0;
        bus.io_guard = '0;
        @(negedge clock);

        // Reset state, then round robin over rules 0 and 2.
        do_reset();
        seq25 = '{0, 1, 3, 1, 3};
        for (int i = 0; i < 5; i++) tick_en("rr_0101 en_a", 1'b1, 7'b0000101, seq25[i]);
        check("rr_0101 fire_count", 32'(bus.io_fire_count), 32'd4);
        tick_en("pause en_a", 1'b0, 7'b0000101, 0);

        // Single top rule, then wrap from rule 6 back to rule 0.
        do_reset();
        tick_en("top first en_a", 1'b1, 7'b1000000, 0);
        for (int i = 0; i < 3; i++) tick_en("top en_a", 1'b1, 7'b1000000, 7);
        for (int i = 0; i < 2; i++) begin
            tick_en("wrap en_a lo", 1'b1, 7'b1000001, 1);
            tick_en("wrap en_a hi", 1'b1, 7'b1000001, 7);
        end
        check("wrap fire", 32'(bus.io_fire), 32'd1);

        // Pause/resume: one cycle of latency on each resume.
        do_reset();
        seq28_run = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        seq28_en  = '{0, 2, 0, 0, 2};
        for (int i = 0; i < 5; i++) tick_en("resume en_a", seq28_run[i], 7'b0000010, seq28_en[i]);

        // Deadlock after exactly LIMIT stalled RUN edges.
        do_reset();
        tick(1'b1, '0);
        for (int i = 0; i < LIMIT - 1; i++) tick(1'b1, '0);
        check("stall 14 deadlock", 32'(bus.io_deadlock), 32'd0);
        tick(1'b1, '0);
        check("stall 15 deadlock", 32'(bus.io_deadlock), 32'd1);
        for (int i = 0; i < 2; i++) tick_en("dead guards en_a", 1'b1, 7'h7F, 0);
        tick(1'b0, 7'h7F);
        check("dead sticky", 32'(bus.io_deadlock), 32'd1);
        check("dead fire_count", 32'(bus.io_fire_count), 32'd0);
        // Reset asserted in DEADLOCK clears it immediately.
        reset = 1'b1;
        #1;
        check("dead async reset", 32'(bus.io_deadlock), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Stall counter clears on a grant and holds while paused.
        tick(1'b1, '0);
        for (int i = 0; i < 8; i++) tick(1'b1, '0);
        tick_en("stall clear en_a", 1'b1, 7'b0000001, 1);
        for (int i = 0; i < LIMIT - 1; i++) tick(1'b1, '0);
        check("stall clear deadlock", 32'(bus.io_deadlock), 32'd0);
        tick(1'b0, '0);
        tick(1'b1, '0);
        check("stall hold deadlock", 32'(bus.io_deadlock), 32'd0);
        tick(1'b1, '0);
        check("stall resume deadlock", 32'(bus.io_deadlock), 32'd1);

        // Asynchronous reset while a rule is being presented.
        do_reset();
        tick_en("mid first en_a", 1'b1, 7'b0001100, 0);
        tick_en("mid issue en_a", 1'b1, 7'b0001100, 3);
        check("mid issue count", 32'(bus.io_fire_count), 32'd1);
        reset = 1'b1;
        #1;
        check("mid reset en_a", 32'(bus.io_en_a), 32'd0);
        check("mid reset fire", 32'(bus.io_fire), 32'd0);
        check("mid reset count", 32'(bus.io_fire_count), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick_en("post reset en_a", 1'b1, 7'b0001100, 0);
        tick_en("post reset first", 1'b1, 7'b0001100, 3);

        // Fire counter wraps from 0xFFFF to 0x0000.
        do_reset();
        tick(1'b1, 7'b0000001);
        for (int i = 0; i < 65535; i++) tick(1'b1, 7'b0000001);
        check("count at ffff", 32'(bus.io_fire_count), 32'h0000_FFFF);
        tick(1'b1, 7'b0000001);
        check("count wrap", 32'(bus.io_fire_count), 32'd0);
        check("wrap en_a", 32'(bus.io_en_a), 32'd1);
        check("wrap deadlock", 32'(bus.io_deadlock), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rule_scheduler.md
RULE_SCHEDULER -- requirements
Module: rule_scheduler

Interface
REQ-001 SHALL have parameter NUM_RULES, default 7, number of guarded rules; legal range 1..(2^EN_W - 1).
REQ-002 SHALL have parameter EN_W, default 3, width of the encoded rule-select output.
REQ-003 SHALL have parameter STALL_LIMIT, default 15, number of consecutive all-guards-false RUN cycles that declares deadlock.
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port io_guard  input  NUM_RULES  bit i high = rule i currently enabled in the downstream system.
REQ-007 SHALL have port io_run  input  1  high = scheduling permitted; low = pause.
REQ-008 SHALL have port io_en_a  output  EN_W  encoded rule select fed to the system's io_en_a; 0 = no rule, k = rule k-1 fires.
REQ-009 SHALL have port io_fire  output  1  high exactly when io_en_a is nonzero.
REQ-010 SHALL have port io_deadlock  output  1  sticky deadlock flag.
REQ-011 SHALL have port io_fire_count  output  16  number of rules issued since reset.

Function
REQ-012 SHALL implement states IDLE, RUN, DEADLOCK; reset state IDLE.
REQ-013 IDLE -> RUN SHALL occur on a cycle with io_run=1; RUN -> IDLE SHALL occur on a cycle with io_run=0.
REQ-014 RUN -> DEADLOCK SHALL occur when the stall counter reaches STALL_LIMIT; DEADLOCK SHALL be left only by reset.
REQ-015 In RUN with any io_guard bit set, the block SHALL select the lowest-indexed set guard at or after (last_granted+1) mod NUM_RULES (round-robin, wrap-around).
REQ-016 Selection SHALL be registered: guards sampled at edge t drive io_en_a=index+1 and io_fire=1 during cycle t+1 (latency 1).
REQ-017 Each issued rule SHALL update last_granted to the selected index and increment io_fire_count by 1, wrapping 0xFFFF -> 0x0000.
REQ-018 io_en_a SHALL be 0 and io_fire 0 in any cycle following an edge in IDLE, DEADLOCK, io_run=0, or all guards low.
REQ-019 The stall counter SHALL increment on each RUN edge with all guards low, clear on any RUN edge with a guard high, hold in IDLE, and saturate at STALL_LIMIT.
REQ-020 io_deadlock SHALL be 1 exactly while in DEADLOCK.
REQ-021 io_run falling in the same cycle as guards are high SHALL issue no rule (pause wins).
REQ-022 Guard bits at index >= NUM_RULES do not exist; io_en_a SHALL never exceed NUM_RULES.

Reset
REQ-023 Asserting reset SHALL immediately force state IDLE, io_en_a=0, io_fire=0, io_deadlock=0, io_fire_count=0, stall counter 0, last_granted=NUM_RULES-1 (so first search starts at rule 0).
REQ-024 Reset asserted mid-operation, including in DEADLOCK, SHALL abandon any pending selection with no rule issued in the following cycle.

Verification
REQ-025 Reset, then io_run=1, io_guard=7'b0000101 constant -> io_en_a sequence 0,1,3,1,3 on successive cycles; io_fire_count=4 after the fifth cycle.
REQ-026 io_run=1, io_guard=7'b1000000 -> io_en_a=7 every cycle after the first; wrap to rule 0 when io_guard changes to 7'b1000001 yields alternating 1,7.
REQ-027 io_run=1, io_guard=0 for 15 cycles -> io_deadlock=1 after the 15th edge; later io_guard=7'h7F keeps io_en_a=0 and io_deadlock=1.
REQ-028 io_run toggled 1,0,1 with io_guard=7'b0000010 -> io_en_a 0,2,0,0,2 (one-cycle latency on each resume); stall counter unchanged while paused.
REQ-029 Assert reset asynchronously mid-cycle while io_fire=1 -> io_en_a, io_fire, io_fire_count drop to 0 before the next edge; after release, first issued rule is lowest set guard.
REQ-030 io_fire_count preloaded to 0xFFFF via 65535 issues -> next issue reads 0x0000 with no other side effect.
